// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the 16-bit pipeline: fetch FSM states, fetch constants
// and the opcode field accessor.
package cpu_pipe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN,
    HALTED
  } fetch_state_t;

  localparam logic [15:0] PC_STEP     = 16'd2;
  localparam logic [15:0] NOP_INST    = 16'h0000;
  localparam logic [3:0]  HALT_OPCODE = 4'hF;

  function automatic logic [3:0] opcode(input logic [15:0] inst);
    return inst[15:12];
  endfunction

endpackage

// File: rtl/if_skid_reg.sv
// Single-entry hold register for one fetched instruction and its pc_out value,
// captured when memory answers while the pipeline is stalled.
module if_skid_reg
  import cpu_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [15:0] pc_in,
  input  logic [15:0] inst_in,
  output logic        valid,
  output logic [15:0] pc,
  output logic [15:0] inst
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= 16'h0000;
      inst  <= NOP_INST;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_in;
      inst  <= inst_in;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the imem req/ready handshake and
// presents pc/inst/bubble to the IF/DF buffer every clock.
//
// state  | meaning
// IDLE   | first cycle after reset, issue the first request
// FETCH  | request outstanding (or about to be issued)
// HOLD   | stalled with a returned instruction parked in the skid
// DRAIN  | redirected while a request was in flight, discard its data
// HALTED | HALT presented, no further fetching until redirect
module if_fetch_unit
  import cpu_pipe_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = cpu_pipe_pkg::HALT_OPCODE,
  parameter logic [15:0] NOP_INST    = cpu_pipe_pkg::NOP_INST,
  parameter logic [15:0] PC_STEP     = cpu_pipe_pkg::PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] pc_out,
  output logic [15:0] inst_out,
  output logic        nop_out,
  output logic        halted
);

  fetch_state_t state, state_d;
  logic [15:0]  pc, pc_d;
  logic         req_d, nop_d, halted_d;
  logic [15:0]  addr_d, pc_out_d, inst_d;
  logic         skid_load, skid_clear, skid_valid;
  logic [15:0]  skid_pc, skid_inst;
  logic [15:0]  next_addr, redir_target;

  assign next_addr    = imem_addr + PC_STEP;
  assign redir_target = {redirect_pc[15:1], 1'b0};

  if_skid_reg u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clear   (skid_clear),
    .pc_in   (next_addr),
    .inst_in (imem_rdata),
    .valid   (skid_valid),
    .pc      (skid_pc),
    .inst    (skid_inst)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      pc_out    <= RESET_PC;
      inst_out  <= NOP_INST;
      nop_out   <= 1'b1;
      halted    <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      imem_req  <= req_d;
      imem_addr <= addr_d;
      pc_out    <= pc_out_d;
      inst_out  <= inst_d;
      nop_out   <= nop_d;
      halted    <= halted_d;
    end
  end

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    req_d      = imem_req;
    addr_d     = imem_addr;
    pc_out_d   = pc_out;
    inst_d     = inst_out;
    nop_d      = nop_out;
    halted_d   = halted;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    if (redirect) begin
      pc_d       = redir_target;
      skid_clear = 1'b1;
      nop_d      = 1'b1;
      halted_d   = 1'b0;
      // An unanswered request cannot be withdrawn, so wait it out in DRAIN.
      if (imem_req && !imem_ready) begin
        state_d = DRAIN;
      end else begin
        state_d = FETCH;
        req_d   = 1'b1;
        addr_d  = redir_target;
      end
    end else begin
      case (state)
        IDLE: begin
          state_d = FETCH;
          req_d   = 1'b1;
          addr_d  = pc;
        end
        FETCH: begin
          if (imem_req) begin
            if (imem_ready) begin
              pc_d = next_addr;
              if (stall) begin
                skid_load = 1'b1;
                req_d     = 1'b0;
                state_d   = HOLD;
              end else begin
                pc_out_d = next_addr;
                inst_d   = imem_rdata;
                nop_d    = 1'b0;
                if (opcode(imem_rdata) == HALT_OPCODE) begin
                  req_d   = 1'b0;
                  state_d = HALTED;
                end else begin
                  addr_d = next_addr;
                end
              end
            end else if (!stall) begin
              nop_d = 1'b1;
            end
          end else if (!stall) begin
            req_d  = 1'b1;
            addr_d = pc;
            nop_d  = 1'b1;
          end
        end
        HOLD: begin
          if (!stall && skid_valid) begin
            pc_out_d   = skid_pc;
            inst_d     = skid_inst;
            nop_d      = 1'b0;
            skid_clear = 1'b1;
            if (opcode(skid_inst) == HALT_OPCODE) begin
              state_d = HALTED;
            end else begin
              state_d = FETCH;
              req_d   = 1'b1;
              addr_d  = pc;
            end
          end
        end
        DRAIN: begin
          nop_d = 1'b1;
          if (imem_ready) begin
            state_d = FETCH;
            req_d   = 1'b1;
            addr_d  = pc;
          end
        end
        HALTED: begin
          req_d    = 1'b0;
          halted_d = 1'b1;
          if (!stall) nop_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a per-cycle vector table covering streaming,
// wait states, stall/skid, drain, halt and wrap, plus hand-written reset sequences.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] pc_out;
  logic [15:0] inst_out;
  logic        nop_out;
  logic        halted;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .pc_out      (pc_out),
    .inst_out    (inst_out),
    .nop_out     (nop_out),
    .halted      (halted)
  );

  typedef struct {
    logic        st;
    logic        rd;
    logic [15:0] rpc;
    logic        rdy;
    logic [15:0] rdata;
    logic        req;
    logic [15:0] addr;
    logic [15:0] pco;
    logic [15:0] inst;
    logic        nop;
    logic        hlt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic rd, input logic [15:0] rpc,
                     input logic rdy, input logic [15:0] rdata,
                     input logic req, input logic [15:0] addr, input logic [15:0] pco,
                     input logic [15:0] inst, input logic nop, input logic hlt);
    vec_t v;
    v.st = st; v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.rdata = rdata;
    v.req = req; v.addr = addr; v.pco = pco; v.inst = inst; v.nop = nop; v.hlt = hlt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic req,
                         input logic [15:0] addr, input logic [15:0] pco,
                         input logic [15:0] inst, input logic nop, input logic hlt);
    chk({tag, ".imem_req"},  idx, {15'd0, imem_req}, {15'd0, req});
    chk({tag, ".imem_addr"}, idx, imem_addr, addr);
    chk({tag, ".pc_out"},    idx, pc_out, pco);
    chk({tag, ".inst_out"},  idx, inst_out, inst);
    chk({tag, ".nop_out"},   idx, {15'd0, nop_out}, {15'd0, nop});
    chk({tag, ".halted"},    idx, {15'd0, halted}, {15'd0, hlt});
  endtask

  initial begin
    //  st rd rpc      rdy rdata     | req addr     pc_out   inst     nop hlt
    add(0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0000, 16'h0000, 16'h0000, 1, 0); //  0 IDLE->FETCH
    add(0, 0, 16'h0000, 1, 16'h1234,   1, 16'h0002, 16'h0002, 16'h1234, 0, 0); //  1 zero-wait
    add(0, 0, 16'h0000, 1, 16'h2345,   1, 16'h0004, 16'h0004, 16'h2345, 0, 0); //  2
    add(0, 0, 16'h0000, 1, 16'h3456,   1, 16'h0006, 16'h0006, 16'h3456, 0, 0); //  3
    add(0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0006, 16'h0006, 16'h3456, 1, 0); //  4 wait 1
    add(0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0006, 16'h0006, 16'h3456, 1, 0); //  5 wait 2
    add(0, 0, 16'h0000, 1, 16'h4567,   1, 16'h0008, 16'h0008, 16'h4567, 0, 0); //  6
    add(0, 0, 16'h0000, 1, 16'h5678,   1, 16'h000A, 16'h000A, 16'h5678, 0, 0); //  7
    add(0, 0, 16'h0000, 1, 16'h6789,   1, 16'h000C, 16'h000C, 16'h6789, 0, 0); //  8
    add(0, 0, 16'h0000, 1, 16'h789A,   1, 16'h000E, 16'h000E, 16'h789A, 0, 0); //  9
    add(0, 0, 16'h0000, 1, 16'h89AB,   1, 16'h0010, 16'h0010, 16'h89AB, 0, 0); // 10
    add(1, 0, 16'h0000, 1, 16'hABCD,   0, 16'h0010, 16'h0010, 16'h89AB, 0, 0); // 11 stall + ready -> skid
    add(1, 0, 16'h0000, 0, 16'h0000,   0, 16'h0010, 16'h0010, 16'h89AB, 0, 0); // 12 held
    add(1, 0, 16'h0000, 0, 16'h0000,   0, 16'h0010, 16'h0010, 16'h89AB, 0, 0); // 13 held
    add(0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0012, 16'h0012, 16'hABCD, 0, 0); // 14 skid presented
    add(0, 0, 16'h0000, 1, 16'hBCDE,   1, 16'h0014, 16'h0014, 16'hBCDE, 0, 0); // 15
    add(0, 1, 16'h0020, 1, 16'h1111,   1, 16'h0020, 16'h0014, 16'hBCDE, 1, 0); // 16 redirect with ready
    add(0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0020, 16'h0014, 16'hBCDE, 1, 0); // 17 wait
    add(0, 1, 16'h0101, 0, 16'h0000,   1, 16'h0020, 16'h0014, 16'hBCDE, 1, 0); // 18 redirect -> DRAIN
    add(0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0020, 16'h0014, 16'hBCDE, 1, 0); // 19 draining
    add(0, 0, 16'h0000, 1, 16'hDEAD,   1, 16'h0100, 16'h0014, 16'hBCDE, 1, 0); // 20 data dropped
    add(0, 0, 16'h0000, 1, 16'h4242,   1, 16'h0102, 16'h0102, 16'h4242, 0, 0); // 21
    add(0, 1, 16'h0040, 1, 16'h2222,   1, 16'h0040, 16'h0102, 16'h4242, 1, 0); // 22
    add(0, 0, 16'h0000, 1, 16'hF000,   0, 16'h0040, 16'h0042, 16'hF000, 0, 0); // 23 HALT presented
    add(0, 0, 16'h0000, 0, 16'h0000,   0, 16'h0040, 16'h0042, 16'hF000, 1, 1); // 24 halted
    add(0, 0, 16'h0000, 0, 16'h0000,   0, 16'h0040, 16'h0042, 16'hF000, 1, 1); // 25
    add(0, 1, 16'h0000, 0, 16'h0000,   1, 16'h0000, 16'h0042, 16'hF000, 1, 0); // 26 resume
    add(0, 0, 16'h0000, 1, 16'h1234,   1, 16'h0002, 16'h0002, 16'h1234, 0, 0); // 27
    add(0, 1, 16'hFFFE, 1, 16'h3333,   1, 16'hFFFE, 16'h0002, 16'h1234, 1, 0); // 28
    add(0, 0, 16'h0000, 1, 16'hCAFE,   1, 16'h0000, 16'h0000, 16'hCAFE, 0, 0); // 29 wrap
    add(0, 0, 16'h0000, 1, 16'h5555,   1, 16'h0002, 16'h0002, 16'h5555, 0, 0); // 30
    add(0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0002, 16'h0002, 16'h5555, 1, 0); // 31
    add(1, 0, 16'h0000, 1, 16'hF123,   0, 16'h0002, 16'h0002, 16'h5555, 1, 0); // 32 HALT into skid
    add(0, 0, 16'h0000, 0, 16'h0000,   0, 16'h0002, 16'h0004, 16'hF123, 0, 0); // 33 skid HALT shown
    add(0, 0, 16'h0000, 0, 16'h0000,   0, 16'h0002, 16'h0004, 16'hF123, 1, 1); // 34
    add(1, 1, 16'h0030, 0, 16'h0000,   1, 16'h0030, 16'h0004, 16'hF123, 1, 0); // 35 redirect beats stall
    add(0, 0, 16'h0000, 0, 16'h0000,   1, 16'h0030, 16'h0004, 16'hF123, 1, 0); // 36 request pending

    #12;
    chk_all("reset", 0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_all("reset_hold", 0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      stall       = vecs[i].st;
      redirect    = vecs[i].rd;
      redirect_pc = vecs[i].rpc;
      imem_ready  = vecs[i].rdy;
      imem_rdata  = vecs[i].rdata;
      @(posedge clk);
      #1;
      chk_all("vec", i, vecs[i].req, vecs[i].addr, vecs[i].pco, vecs[i].inst,
              vecs[i].nop, vecs[i].hlt);
      @(negedge clk);
    end

    // Reset asserted mid-cycle with a request outstanding must clear outputs at once.
    stall = 1'b0; redirect = 1'b0; imem_ready = 1'b0; imem_rdata = 16'h0000;
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_rst", 0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    imem_ready = 1'b1;
    imem_rdata = 16'h0777;
    @(posedge clk);
    #1;
    chk_all("post_rst", 1, 1'b1, 16'h0002, 16'h0002, 16'h0777, 1'b0, 1'b0);
    @(negedge clk);
    imem_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
